// File: rtl/sfx_event_sequencer.sv
// Sound-effect sequencer: edge-detected game events become prioritised,
// frame-timed effects on the APU effect voice, ducking BGM while one plays.
module sfx_event_sequencer #(
    parameter int NUM_EVENTS    = 4,
    parameter int EFFECT_FRAMES = 16,
    parameter int GAP_FRAMES    = 2,
    parameter bit DUCK_BGM      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_tick,
    input  logic [NUM_EVENTS-1:0] event_req,
    input  logic                  bgm_enable_in,
    output logic                  effect_valid,
    output logic [2:0]            effect_code,
    output logic [4:0]            effect_frame,
    output logic                  bgm_ena,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t                state;
    logic [NUM_EVENTS-1:0] prev;
    logic [NUM_EVENTS-1:0] pending;
    logic [NUM_EVENTS-1:0] rise;
    logic [NUM_EVENTS-1:0] clr;
    logic [2:0]            win;
    logic [2:0]            gap_cnt;
    logic                  any;
    logic                  preempt;
    logic                  last;
    logic                  start;
    logic                  nxt_valid;

    always_comb begin
        rise = event_req & ~prev;
        any  = |pending;
        win  = '0;
        for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
            if (pending[i]) win = 3'(i);
        end
        preempt = (state == PLAY) && any &&
                  (({1'b0, win} + 4'd1) < {1'b0, effect_code});
        last    = effect_frame == 5'(EFFECT_FRAMES - 1);
        start   = frame_tick && any &&
                  ((state == IDLE) || preempt ||
                   ((state == PLAY) && last && (GAP_FRAMES == 0)));
        clr     = start ? (NUM_EVENTS'(1) << win) : '0;
        // Value effect_valid takes at this edge, so bgm_ena lines up with it
        nxt_valid = effect_valid;
        if (frame_tick) begin
            if (start)
                nxt_valid = 1'b1;
            else if (state == PLAY && last)
                nxt_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            prev         <= '1;
            pending      <= '0;
            gap_cnt      <= '0;
            effect_valid <= 1'b0;
            effect_code  <= '0;
            effect_frame <= '0;
            bgm_ena      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            prev    <= event_req;
            pending <= (pending & ~clr) | rise;
            bgm_ena <= bgm_enable_in & ~(DUCK_BGM & nxt_valid);
            if (frame_tick) begin
                if (start) begin
                    state        <= PLAY;
                    busy         <= 1'b1;
                    effect_valid <= 1'b1;
                    effect_code  <= win + 3'd1;
                    effect_frame <= '0;
                end else begin
                    unique case (state)
                        PLAY: begin
                            if (last) begin
                                effect_valid <= 1'b0;
                                effect_code  <= '0;
                                effect_frame <= '0;
                                gap_cnt      <= '0;
                                if (GAP_FRAMES > 0) begin
                                    state <= GAP;
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                effect_frame <= effect_frame + 5'd1;
                            end
                        end
                        GAP: begin
                            if (gap_cnt == 3'(GAP_FRAMES - 1)) begin
                                state   <= IDLE;
                                busy    <= 1'b0;
                                gap_cnt <= '0;
                            end else begin
                                gap_cnt <= gap_cnt + 3'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sfx_event_sequencer.sv
// Bench for sfx_event_sequencer: directed scenarios plus random traffic,
// every cycle compared against a queue-of-pending-events reference model.
module tb_sfx_event_sequencer;

    localparam int EF = 16;
    localparam int GF = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [3:0] event_req = '0;
    logic       bgm_enable_in = 1'b1;
    logic       effect_valid;
    logic [2:0] effect_code;
    logic [4:0] effect_frame;
    logic       bgm_ena;
    logic       busy;

    sfx_event_sequencer #(
        .NUM_EVENTS(4),
        .EFFECT_FRAMES(EF),
        .GAP_FRAMES(GF),
        .DUCK_BGM(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_tick(frame_tick),
        .event_req(event_req),
        .bgm_enable_in(bgm_enable_in),
        .effect_valid(effect_valid),
        .effect_code(effect_code),
        .effect_frame(effect_frame),
        .bgm_ena(bgm_ena),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: playing index (-1 none), frames elapsed, gap left
    logic [3:0] m_prev = '1;
    logic [3:0] m_pend = '0;
    int         m_play = -1;
    int         m_elapsed = 0;
    int         m_gap = 0;
    logic       m_bgm = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      tag, got, exp, $time);
    endtask

    function automatic int lowest(input logic [3:0] p);
        for (int i = 0; i < 4; i++) if (p[i]) return i;
        return -1;
    endfunction

    task automatic model_step();
        logic [3:0] rise;
        logic [3:0] clr;
        int         p;
        if (!rst_n) begin
            m_prev    = '1;
            m_pend    = '0;
            m_play    = -1;
            m_elapsed = 0;
            m_gap     = 0;
            m_bgm     = 1'b0;
        end else begin
            rise   = event_req & ~m_prev;
            m_prev = event_req;
            clr    = '0;
            if (frame_tick) begin
                p = lowest(m_pend);
                if (m_gap > 0) begin
                    m_gap--;
                end else if (m_play >= 0) begin
                    if (p >= 0 && p < m_play) begin
                        m_play    = p;
                        m_elapsed = 0;
                        clr[p]    = 1'b1;
                    end else if (m_elapsed == EF - 1) begin
                        m_play    = -1;
                        m_elapsed = 0;
                        m_gap     = GF;
                    end else begin
                        m_elapsed++;
                    end
                end else if (p >= 0) begin
                    m_play    = p;
                    m_elapsed = 0;
                    clr[p]    = 1'b1;
                end
            end
            m_pend = (m_pend & ~clr) | rise;
            m_bgm  = bgm_enable_in && (m_play < 0);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] req,
                        input logic t);
        @(negedge clk);
        rst_n      = r;
        event_req  = req;
        frame_tick = t;
        @(posedge clk);
        model_step();
        #1;
        chk("valid", int'(effect_valid), int'(m_play >= 0));
        chk("code", int'(effect_code), m_play + 1);
        chk("frame", int'(effect_frame), m_elapsed);
        chk("bgm_ena", int'(bgm_ena), int'(m_bgm));
        chk("busy", int'(busy), int'(m_play >= 0 || m_gap > 0));
    endtask

    // One 4-cycle frame; pulse lands one cycle after the tick
    task automatic frame(input logic [3:0] hold, input logic [3:0] pulse);
        step(1'b1, hold, 1'b1);
        step(1'b1, hold | pulse, 1'b0);
        step(1'b1, hold, 1'b0);
        step(1'b1, hold, 1'b0);
    endtask

    task automatic frames(input int n, input logic [3:0] hold);
        for (int i = 0; i < n; i++) frame(hold, 4'b0000);
    endtask

    initial begin
        logic [3:0] req;
        int         per;
        int         ph;

        // 1: line high through reset release never triggers
        step(1'b0, 4'b0001, 1'b0);
        step(1'b0, 4'b0001, 1'b0);
        frames(40, 4'b0001);
        frames(2, 4'b0000);

        // 2: single pulse on line 2, full effect plus gap
        frame(4'b0000, 4'b0100);
        frames(20, 4'b0000);

        // 3: preempt at frame 5 by line 0
        frame(4'b0000, 4'b0100);
        frames(5, 4'b0000);
        frame(4'b0000, 4'b0001);
        frames(20, 4'b0000);

        // 4: lower priority requests queue behind code 1
        frame(4'b0000, 4'b0001);
        frame(4'b0000, 4'b1000);
        frame(4'b0000, 4'b0010);
        frames(60, 4'b0000);

        // 5: rise coincident with the tick waits one frame
        step(1'b1, 4'b0100, 1'b1);
        step(1'b1, 4'b0100, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        frames(20, 4'b0000);

        // 6: reset mid-play with a queued event
        frame(4'b0000, 4'b0010);
        frames(2, 4'b0000);
        frame(4'b0000, 4'b0100);
        frames(4, 4'b0000);
        step(1'b0, 4'b0000, 1'b0);
        frames(30, 4'b0000);

        // Random traffic with jittered frame period and rare resets
        req = '0;
        per = 4;
        ph  = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
            if ($urandom_range(0, 63) == 0)
                bgm_enable_in = ~bgm_enable_in;
            if (ph == 0) per = int'($urandom_range(2, 5));
            step($urandom_range(0, 599) != 0, req, ph == 0);
            ph = (ph + 1 >= per) ? 0 : ph + 1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
